// File: rtl/port_read_scheduler.sv
// Per-output-port read scheduler: picks one of the priority queues by
// strict priority or WRR, issues one read request and waits for eop.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   sp0_wrr1          0 = strict priority, 1 = WRR (sampled in IDLE)
//   prepared, ready   per-queue packet-present / downstream-accept
//   wrr_weight        per-queue WRR weight, queue q at [q*W +: W]
//   grant_ack         cache manager accepted the request (REQ only)
//   pkt_done          eop of the granted packet read (XFER only)
//   rea               read request, held until grant_ack
//   rd_priority       queue being requested / transferred
//   busy              high in REQ and XFER
//   pkt_cnt           grants since reset, wraps
module port_read_scheduler #(
  parameter int num_of_priority  = 8,
  parameter int priority_width   = 3,
  parameter int wrr_weight_width = 4,
  parameter int cnt_width        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sp0_wrr1,
  input  logic [num_of_priority-1:0] prepared,
  input  logic [num_of_priority-1:0] ready,
  input  logic [num_of_priority*wrr_weight_width-1:0] wrr_weight,
  input  logic                       grant_ack,
  input  logic                       pkt_done,
  output logic                       rea,
  output logic [priority_width-1:0]  rd_priority,
  output logic                       busy,
  output logic [cnt_width-1:0]       pkt_cnt
);

  localparam int N  = num_of_priority;
  localparam int PW = priority_width;
  localparam int WW = wrr_weight_width;
  localparam int CW = cnt_width;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER
  } state_e;

  state_e          state_q, state_d;
  logic            rea_q, rea_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   pri_q, pri_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   crd_q, crd_d;
  logic            wrr_q, wrr_d;

  logic [N-1:0]    elig;
  logic            any_elig;
  logic [PW-1:0]   sp_sel;
  logic [PW-1:0]   scan_sel;
  logic            keep_ptr;
  logic [WW-1:0]   w_sel;
  logic [WW-1:0]   w_load;

  assign elig     = prepared & ready;
  assign any_elig = |elig;

  // Lowest index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    sp_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) sp_sel = PW'(i);
    end
  end

  // Round-robin scan starts just after ptr and ends on ptr itself,
  // so a lone eligible queue at ptr can still be reselected.
  always_comb begin
    logic found;
    int   j;
    found    = 1'b0;
    scan_sel = ptr_q;
    j        = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr_q) + i) % N;
      if (!found && elig[j]) begin
        found    = 1'b1;
        scan_sel = PW'(j);
      end
    end
  end

  assign keep_ptr = elig[ptr_q] && (crd_q != '0);
  assign w_sel    = wrr_weight[int'(scan_sel)*WW +: WW];
  // A zero weight would starve the queue forever; treat it as 1.
  assign w_load   = (w_sel == '0) ? WW'(1) : w_sel;

  always_comb begin
    state_d = state_q;
    rea_d   = rea_q;
    busy_d  = busy_q;
    pri_d   = pri_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    crd_d   = crd_q;
    wrr_d   = wrr_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          state_d = S_REQ;
          rea_d   = 1'b1;
          busy_d  = 1'b1;
          wrr_d   = sp0_wrr1;
          if (!sp0_wrr1) begin
            pri_d = sp_sel;
          end else if (keep_ptr) begin
            pri_d = ptr_q;
          end else begin
            pri_d = scan_sel;
            ptr_d = scan_sel;
            crd_d = w_load;
          end
        end
      end
      S_REQ: begin
        if (grant_ack) begin
          state_d = S_XFER;
          rea_d   = 1'b0;
          cnt_d   = cnt_q + CW'(1);
          // Credit is only spent by grants issued in WRR mode.
          if (wrr_q && crd_q != '0) begin
            crd_d = crd_q - WW'(1);
          end
        end
      end
      S_XFER: begin
        if (pkt_done) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        rea_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rea_q   <= 1'b0;
      busy_q  <= 1'b0;
      pri_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= PW'(N - 1);
      crd_q   <= '0;
      wrr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rea_q   <= rea_d;
      busy_q  <= busy_d;
      pri_q   <= pri_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      crd_q   <= crd_d;
      wrr_q   <= wrr_d;
    end
  end

  assign rea         = rea_q;
  assign busy        = busy_q;
  assign rd_priority = pri_q;
  assign pkt_cnt     = cnt_q;

endmodule

// File: tb/tb_port_read_scheduler.sv
// Directed bench for port_read_scheduler: SP, WRR, handshake corners,
// counter wrap (narrow-counter instance) and async reset mid-transfer.
module tb_port_read_scheduler;

  logic        clk;
  logic        rst;
  logic        sp0_wrr1;
  logic [7:0]  prepared;
  logic [7:0]  ready;
  logic [31:0] wrr_weight;
  logic        grant_ack;
  logic        pkt_done;
  logic        rea;
  logic [2:0]  rd_priority;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic        rea_w;
  logic [2:0]  rd_priority_w;
  logic        busy_w;
  logic [1:0]  pkt_cnt_w;

  int          n_tests;
  int          n_fail;
  logic [15:0] exp_cnt;
  logic [2:0]  seq [10];

  port_read_scheduler u_dut (
    .clk         (clk),
    .rst         (rst),
    .sp0_wrr1    (sp0_wrr1),
    .prepared    (prepared),
    .ready       (ready),
    .wrr_weight  (wrr_weight),
    .grant_ack   (grant_ack),
    .pkt_done    (pkt_done),
    .rea         (rea),
    .rd_priority (rd_priority),
    .busy        (busy),
    .pkt_cnt     (pkt_cnt)
  );

  port_read_scheduler #(.cnt_width(2)) u_dut_w (
    .clk         (clk),
    .rst         (rst),
    .sp0_wrr1    (sp0_wrr1),
    .prepared    (prepared),
    .ready       (ready),
    .wrr_weight  (wrr_weight),
    .grant_ack   (grant_ack),
    .pkt_done    (pkt_done),
    .rea         (rea_w),
    .rd_priority (rd_priority_w),
    .busy        (busy_w),
    .pkt_cnt     (pkt_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    cyc();
    #2 rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic wait_rea(output int n);
    n = 0;
    while (!rea && n < 20) begin
      cyc();
      n++;
    end
    chk("rea_up", rea, 1);
  endtask

  task automatic finish_pkt();
    grant_ack = 1'b1;
    cyc();
    grant_ack = 1'b0;
    exp_cnt++;
    chk("rea_drop", rea, 0);
    chk("busy_xfer", busy, 1);
    chk("pkt_cnt", pkt_cnt, exp_cnt);
    chk("pkt_cnt_w", pkt_cnt_w, exp_cnt[1:0]);
    cyc();
    cyc();
    pkt_done = 1'b1;
    cyc();
    pkt_done = 1'b0;
    chk("busy_done", busy, 0);
  endtask

  task automatic serve(input logic [2:0] exp_pri, input int exp_wait,
                       input int ack_dly);
    int n;
    wait_rea(n);
    chk("rea_lat", n, exp_wait);
    chk("rd_pri", rd_priority, exp_pri);
    chk("busy_req", busy, 1);
    repeat (ack_dly) begin
      cyc();
      chk("rea_hold", rea, 1);
    end
    finish_pkt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_tests    = 0;
    n_fail     = 0;
    exp_cnt    = '0;
    rst        = 1'b0;
    sp0_wrr1   = 1'b0;
    prepared   = '0;
    ready      = 8'hFF;
    wrr_weight = '0;
    grant_ack  = 1'b0;
    pkt_done   = 1'b0;

    cyc();
    cyc();
    chk("rst_rea", rea, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pri", rd_priority, 0);
    chk("rst_cnt", pkt_cnt, 0);

    // Strict priority basic
    prepared = 8'b1010_0100;
    rst_pulse();
    serve(3'd2, 1, 2);
    prepared[2] = 1'b0;
    serve(3'd5, 1, 2);
    prepared[5] = 1'b0;
    serve(3'd7, 1, 2);
    prepared[7] = 1'b0;

    // Strict priority with backpressure, request held when queue drops
    prepared = 8'hFF;
    ready    = 8'b1111_1100;
    wait_rea(n);
    chk("bp_pri", rd_priority, 2);
    prepared[2] = 1'b0;
    repeat (3) begin
      cyc();
      chk("bp_rea", rea, 1);
      chk("bp_pri_hold", rd_priority, 2);
    end
    finish_pkt();
    serve(3'd3, 1, 0);
    prepared = '0;
    ready    = 8'hFF;

    // grant_ack / pkt_done outside their states are ignored
    grant_ack = 1'b1;
    cyc();
    cyc();
    grant_ack = 1'b0;
    chk("idle_ack_rea", rea, 0);
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_cnt", pkt_cnt, exp_cnt);
    pkt_done = 1'b1;
    cyc();
    pkt_done = 1'b0;
    chk("idle_done_busy", busy, 0);
    prepared = 8'h01;
    wait_rea(n);
    chk("hs_pri", rd_priority, 0);
    grant_ack = 1'b1;
    pkt_done  = 1'b1;
    cyc();
    grant_ack = 1'b0;
    pkt_done  = 1'b0;
    exp_cnt++;
    prepared = '0;
    chk("hs_rea", rea, 0);
    chk("hs_busy", busy, 1);
    chk("hs_cnt", pkt_cnt, exp_cnt);
    repeat (3) begin
      cyc();
      chk("hs_xfer_hold", busy, 1);
    end
    pkt_done = 1'b1;
    cyc();
    pkt_done = 1'b0;
    chk("hs_done", busy, 0);

    // WRR: q0=3, q1=1, q2=0 (as 1), others 2; queues 0..2 eligible
    sp0_wrr1   = 1'b1;
    wrr_weight = 32'h2222_2013;
    prepared   = 8'h07;
    rst_pulse();
    seq = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2};
    for (int i = 0; i < 10; i++) serve(seq[i], 1, 0);

    // WRR wrap and hole: only 1 and 6 eligible, weights 1
    wrr_weight = 32'h1111_1111;
    prepared   = 8'b0100_0010;
    rst_pulse();
    serve(3'd1, 1, 0);
    serve(3'd6, 1, 0);
    serve(3'd1, 1, 0);
    serve(3'd6, 1, 0);

    // Async reset in the middle of a transfer
    prepared = 8'h20;
    wait_rea(n);
    chk("rx_pri", rd_priority, 5);
    grant_ack = 1'b1;
    cyc();
    grant_ack = 1'b0;
    exp_cnt++;
    chk("rx_cnt", pkt_cnt, exp_cnt);
    prepared = 8'h30;
    cyc();
    #2 rst = 1'b0;
    #1;
    chk("rx_rea", rea, 0);
    chk("rx_busy", busy, 0);
    chk("rx_cnt0", pkt_cnt, 0);
    chk("rx_pri0", rd_priority, 0);
    cyc();
    rst = 1'b1;
    exp_cnt = '0;
    serve(3'd4, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/port_read_scheduler.md
# port_read_scheduler

Per-output-port read scheduler that sits between the cache manager and one output port of the switch. It chooses which of the 8 priority queues of that port is read next, using strict priority or weighted round robin as selected by `sp0_wrr1`. It issues one packet-read request at a time to the cache manager and holds off until that packet's last word has left. One instance is built per output port (16 in the top level).

## Interface
- `num_of_priority`, 8, number of priority queues per port
- `priority_width`, 3, width of a queue index
- `wrr_weight_width`, 4, width of one WRR weight
- `cnt_width`, 16, width of the granted-packet statistic counter

Ports:
- `clk`  in  1  single clock for the whole block
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `sp0_wrr1`  in  1  0 = strict priority, 1 = WRR; sampled only in IDLE
- `prepared`  in  num_of_priority  bit q = 1: queue q holds at least one complete packet
- `ready`  in  num_of_priority  bit q = 1: downstream accepts priority q
- `wrr_weight`  in  num_of_priority*wrr_weight_width  weight of queue q in bits [q*W+W-1 : q*W]
- `grant_ack`  in  1  cache manager has accepted the current request
- `pkt_done`  in  1  last word (eop) of the granted packet was read this cycle
- `rea`  out  1  read request; held high until acknowledged
- `rd_priority`  out  priority_width  queue index being requested or transferred
- `busy`  out  1  high in REQ and XFER
- `pkt_cnt`  out  cnt_width  number of grants since reset; wraps modulo 2^cnt_width

## Operation
- eligible = prepared & ready.
- FSM states: IDLE, REQ, XFER.
  - IDLE, eligible == 0: stay in IDLE.
  - IDLE, eligible != 0: select a queue, latch it into `rd_priority`, then go to REQ.
  - REQ: `rea` = 1 and `rd_priority` is frozen. The request is never withdrawn, even if `prepared` or `ready` drops.
  - REQ, grant_ack = 1: go to XFER; `pkt_cnt` increments; WRR credit is consumed.
  - XFER, pkt_done = 1: go to IDLE.
- `pkt_done` is ignored outside XFER, including a `pkt_done` that coincides with `grant_ack` in REQ.
- `grant_ack` is ignored outside REQ.
- Strict priority: choose the lowest-index eligible queue. Queue 0 is the highest priority.
- WRR state: pointer `ptr` (priority_width bits) and credit `crd` (wrr_weight_width bits).
  - If eligible[ptr] and crd != 0: select ptr.
  - Otherwise: select the first eligible queue scanning ptr+1, ptr+2, … modulo num_of_priority. The scan ends at ptr itself, so ptr can be reselected.
  - After that scan: set ptr = selected queue and crd = wrr_weight[selected]. A weight of 0 is loaded as 1.
  - On grant_ack: crd decrements by 1 and saturates at 0.
- Mode switch: `ptr`/`crd` keep their values while in SP mode. They are used as-is when WRR resumes.
- `wrr_weight` is read only at reload time. Changes never affect the current credit.

## Timing
- Reset values: state IDLE, `rea`=0, `rd_priority`=0, `busy`=0, `pkt_cnt`=0, `ptr`=num_of_priority-1, `crd`=0. With these values the first WRR scan starts at queue 0.
- Reset asserted mid-operation forces all of the above immediately, asynchronously. Any request in flight is dropped.
- All outputs are registered.
- eligible != 0 sampled in IDLE at cycle t → `rea`=1 and `busy`=1 at t+1.
- `grant_ack` sampled high at cycle a → `rea`=0 at a+1, and `pkt_cnt` is updated at a+1.
- `pkt_done` sampled high in XFER at cycle d → `busy`=0 at d+1. The earliest next `rea` is at d+2.
- Minimum packet-to-packet request spacing is therefore 3 cycles: REQ(1) + XFER(≥1) + IDLE(1).
- Selection arithmetic: index addition is modulo num_of_priority; `pkt_cnt` wraps from 2^cnt_width-1 to 0.

## Test plan
- SP basic: sp0_wrr1=0, prepared=8'b1010_0100, ready=8'hFF. `grant_ack` 2 cycles after `rea`, `pkt_done` 3 cycles after that. Expected: `rd_priority` = 2, then 5, then 7 as each queue's prepared bit is cleared after service, and `rea` rises exactly 1 cycle after IDLE.
- SP with backpressure: prepared=8'hFF, ready=8'b1111_1100. Expected: `rd_priority`=2. Then drop `prepared[2]` while in REQ: `rea` stays high, `rd_priority` stays 2 until `grant_ack`.
- WRR weights: sp0_wrr1=1, weights q0=3, q1=1, q2=0, others=2; queues 0–2 always eligible, others not. Expected grant sequence 0,0,0,1,2,0,0,0,1,2… (weight 0 behaves as 1).
- WRR wrap and hole: only queues 6 and 1 eligible, all weights 1, ptr reset. Expected grants 1,6,1,6; the scan wraps from 7 to 0.
- Handshake corners: `grant_ack` asserted in IDLE → no effect. `grant_ack` and `pkt_done` both high in REQ → XFER entered and a later `pkt_done` is still required. `pkt_cnt` preset near 16'hFFFF wraps to 0 on grant.
- Reset mid-XFER: drive `rst`=0 asynchronously between clock edges. Expected: `rea`/`busy`/`pkt_cnt`/`rd_priority` become 0 before the next edge; after release, the first WRR grant goes to the lowest eligible queue.
